// File: rtl/mult_ctrl.sv
// Sequencing controller for the N-bit shift-add multiplier.
// Drives the Load/Ad/Sh strobes of the ACC register and pulses Done when the
// product is valid. M is the current multiplier LSB read back from ACC.
module mult_ctrl #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBit,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_bit;

  // The counter holds the index of the bit being processed.
  assign last_bit = (cnt_q == CW'(N - 1));

  // State and bit counter registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and strobe decode (Ad/Sh in StBit follow M).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Load    = 1'b0;
    Ad      = 1'b0;
    Sh      = 1'b0;
    Done    = 1'b0;
    Busy    = 1'b1;
    unique case (state_q)
      StIdle: begin
        Busy = 1'b0;
        if (St) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        Load    = 1'b1;
        cnt_d   = '0;
        state_d = StBit;
      end
      StBit: begin
        if (M) begin
          // Add first; LSB is untouched so the following shift sees the same bit.
          Ad      = 1'b1;
          state_d = StShift;
        end else begin
          Sh = 1'b1;
          if (last_bit) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = StBit;
          end
        end
      end
      StShift: begin
        Sh = 1'b1;
        if (last_bit) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = StBit;
        end
      end
      StDone: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        Busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: a behavioural ACC closes the M loop,
// and each multiply is checked cycle by cycle against a strobe sequence
// derived from the multiplier bits, plus the final product.
module tb_mult_ctrl;

  localparam int unsigned N = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic St  = 1'b0;
  logic M;
  logic Load, Ad, Sh, Busy, Done;

  logic [32:0] acc = '0;
  logic [15:0] mplier_r = '0;
  logic [15:0] mcand_r  = '0;

  int vectors = 0;
  int errors  = 0;

  mult_ctrl #(.N(N)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .St   (St),
    .M    (M),
    .Load (Load),
    .Ad   (Ad),
    .Sh   (Sh),
    .Busy (Busy),
    .Done (Done)
  );

  always #5 Clk = ~Clk;

  // Environment model of the ACC register.
  assign M = acc[0];
  always @(posedge Clk) begin
    if (Load)    acc <= {17'b0, mplier_r};
    else if (Ad) acc <= {acc[32:16] + {1'b0, mcand_r}, acc[15:0]};
    else if (Sh) acc <= acc >> 1;
  end

  function automatic logic [4:0] outs();
    return {Load, Ad, Sh, Done, Busy};
  endfunction

  // One multiply from IDLE. Expected strobe sequence comes straight from the
  // algorithm: Load, then per bit (Ad,Sh) or (Sh), then Done.
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input bit toggle,
                          input bit hold, input int abort_at, input string name);
    logic [4:0]  exp_q[$];
    logic [4:0]  got;
    logic [32:0] prod;
    int          total;
    exp_q = {};
    exp_q.push_back(5'b10001);
    for (int i = 0; i < int'(N); i++) begin
      if (a[i]) exp_q.push_back(5'b01001);
      exp_q.push_back(5'b00101);
    end
    exp_q.push_back(5'b00011);
    total = exp_q.size();
    prod  = {1'b0, 32'(a) * 32'(b)};
    mplier_r = a;
    mcand_r  = b;
    St = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= total; c++) begin
      @(negedge Clk);
      got = outs();
      vectors++;
      if (got !== exp_q[c-1]) begin
        errors++;
        $display("FAIL %s cycle %0d: LoadAdShDoneBusy got %b expected %b",
                 name, c, got, exp_q[c-1]);
      end
      if (c == total) begin
        vectors++;
        if (acc !== prod) begin
          errors++;
          $display("FAIL %s product: got %h expected %h", name, acc, prod);
        end
      end
      if (c == abort_at) begin
        Rst = 1'b0;
        St  = 1'b0;
        @(negedge Clk);
        got = outs();
        vectors++;
        if (got !== 5'b00000) begin
          errors++;
          $display("FAIL %s abort: outputs got %b expected 00000", name, got);
        end
        Rst = 1'b1;
        return;
      end
      if (hold)                      St = 1'b1;
      else if (toggle && c < total)  St = 1'($urandom % 2);
      else                           St = 1'b0;
    end
    @(negedge Clk);
    got = outs();
    vectors++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL %s idle after done: got %b expected 00000", name, got);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    Rst = 1'b0;
    St  = 1'b1;
    mplier_r = 16'h1234;
    mcand_r  = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      got = outs();
      vectors++;
      if (got !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected 00000", i, got);
      end
    end
    Rst = 1'b1;
    @(negedge Clk);
    got = outs();
    vectors++;
    if (got !== 5'b10001) begin
      errors++;
      $display("FAIL reset_release: got %b expected 10001", got);
    end
    Rst = 1'b0;
    St  = 1'b0;
    @(negedge Clk);
    got = outs();
    vectors++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset_reassert: got %b expected 00000", got);
    end
    Rst = 1'b1;
  endtask

  task automatic test_zero();
    run_mult(16'h0000, 16'($urandom), 1'b0, 1'b0, 0, "zero");
  endtask

  task automatic test_ones();
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, "ones");
  endtask

  task automatic test_five_three();
    run_mult(16'h0005, 16'h0003, 1'b0, 1'b0, 0, "five_three");
  endtask

  task automatic test_mid_reset();
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 10, "mid_reset");
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_st_toggle();
    for (int i = 0; i < 3; i++) begin
      run_mult(16'($urandom), 16'($urandom), 1'b1, 1'b0, 0, "st_toggle");
    end
  endtask

  task automatic test_back_to_back();
    run_mult(16'($urandom), 16'($urandom), 1'b0, 1'b1, 0, "b2b_first");
    run_mult(16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_mult(16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ones();
    test_five_three();
    test_mid_reset();
    test_st_toggle();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
